// File: rtl/projectile_flight.sv
// Flies one projectile per launch: integrates position once per frame tick under gravity,
// then reports hit/miss against the target window on landing or miss on leaving the screen.
module projectile_flight #(
    parameter int START_X_L = 100,
    parameter int START_X_R = 924,
    parameter int START_Y   = 500,
    parameter int GROUND_Y  = 700,
    parameter int SCREEN_W  = 1024,
    parameter int VY0       = 16,
    parameter int G         = 1,
    parameter int VY_MAX    = 31
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        launch_i,
    input  logic [4:0]  speed_i,
    input  logic        turn_i,
    input  logic        frame_tick_i,
    input  logic [11:0] target_lo_i,
    input  logic [11:0] target_hi_i,
    output logic [11:0] ball_x_o,
    output logic [11:0] ball_y_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        hit_o,
    output logic        miss_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_END    = 2'd2;

    localparam logic [11:0]        X_L      = 12'(START_X_L);
    localparam logic [11:0]        X_R      = 12'(START_X_R);
    localparam logic [11:0]        Y_START  = 12'(START_Y);
    localparam logic [11:0]        Y_GROUND = 12'(GROUND_Y);
    localparam logic [11:0]        X_LAST   = 12'(SCREEN_W - 1);
    localparam logic signed [12:0] SCR_W    = 13'(SCREEN_W);
    localparam logic signed [12:0] GND      = 13'(GROUND_Y);
    localparam logic signed [7:0]  VY_INIT  = 8'(-VY0);
    localparam logic signed [8:0]  VY_SAT   = 9'(VY_MAX);
    localparam logic signed [8:0]  G9       = 9'(G);

    logic [1:0]         state_q, state_d;
    logic [11:0]        x_q, x_d;
    logic [11:0]        y_q, y_d;
    logic signed [7:0]  vy_q, vy_d;
    logic [4:0]         vx_q, vx_d;
    logic               dir_q, dir_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               done_q, done_d;

    logic signed [12:0] x_next;
    logic signed [12:0] y_next;
    logic signed [8:0]  vy_sum;
    logic               off_screen;
    logic               in_window;
    logic               do_launch;

    assign x_next     = dir_q ? ($signed({1'b0, x_q}) - $signed({8'b0, vx_q}))
                              : ($signed({1'b0, x_q}) + $signed({8'b0, vx_q}));
    assign y_next     = $signed({1'b0, y_q}) + $signed({{5{vy_q[7]}}, vy_q});
    assign vy_sum     = $signed({vy_q[7], vy_q}) + G9;
    assign off_screen = (x_next < 13'sd0) || (x_next >= SCR_W);
    assign in_window  = (x_next[11:0] >= target_lo_i) && (x_next[11:0] <= target_hi_i);
    // END lasts two cycles (settle, then done pulse); a launch is accepted on the pulse cycle's exit edge.
    assign do_launch  = launch_i && ((state_q == S_IDLE) || (state_q == S_END && done_q));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        vx_d    = vx_q;
        dir_d   = dir_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        done_d  = done_q;
        case (state_q)
            S_FLIGHT: begin
                if (frame_tick_i) begin
                    if (off_screen) begin
                        x_d     = (x_next < 13'sd0) ? 12'd0 : X_LAST;
                        y_d     = y_next[11:0];
                        miss_d  = 1'b1;
                        state_d = S_END;
                    end else if (y_next >= GND) begin
                        x_d     = x_next[11:0];
                        y_d     = Y_GROUND;
                        hit_d   = in_window;
                        miss_d  = !in_window;
                        state_d = S_END;
                    end else begin
                        x_d  = x_next[11:0];
                        y_d  = y_next[11:0];
                        vy_d = (vy_sum > VY_SAT) ? VY_SAT[7:0] : vy_sum[7:0];
                    end
                end
            end
            S_END: begin
                done_d = !done_q;
                if (done_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (do_launch) begin
            vx_d    = speed_i;
            dir_d   = turn_i;
            x_d     = turn_i ? X_R : X_L;
            y_d     = Y_START;
            vy_d    = VY_INIT;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_FLIGHT;
        end
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= X_L;
            y_q     <= Y_START;
            vy_q    <= 8'sd0;
            vx_q    <= 5'd0;
            dir_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            vx_q    <= vx_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
        end
    end

    assign ball_x_o = x_q;
    assign ball_y_o = y_q;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign hit_o    = hit_q;
    assign miss_o   = miss_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_projectile_flight.sv
// Bench for projectile_flight: a trajectory model fills expected queues per shot, and a monitor
// checks every position update and every done pulse against them.
module tb_projectile_flight;

    localparam int SX_L = 100;
    localparam int SX_R = 924;
    localparam int SY   = 500;
    localparam int GY   = 700;
    localparam int SW   = 1024;

    logic        clk60MHz = 1'b0;
    logic        rst_n;
    logic        launch_i;
    logic [4:0]  speed_i;
    logic        turn_i;
    logic        frame_tick_i;
    logic [11:0] target_lo_i;
    logic [11:0] target_hi_i;
    logic [11:0] ball_x_o;
    logic [11:0] ball_y_o;
    logic        busy_o;
    logic        done_o;
    logic        hit_o;
    logic        miss_o;
    logic [1:0]  state_o;

    projectile_flight dut (
        .clk60MHz     (clk60MHz),
        .rst_n        (rst_n),
        .launch_i     (launch_i),
        .speed_i      (speed_i),
        .turn_i       (turn_i),
        .frame_tick_i (frame_tick_i),
        .target_lo_i  (target_lo_i),
        .target_hi_i  (target_hi_i),
        .ball_x_o     (ball_x_o),
        .ball_y_o     (ball_y_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hit_o        (hit_o),
        .miss_o       (miss_o),
        .state_o      (state_o)
    );

    always #8 clk60MHz = ~clk60MHz;

    int vectors     = 0;
    int miscompares = 0;

    // Entries are {x[11:0], y[11:0], hit, miss}.
    logic [25:0] plan_q[$];
    logic [25:0] pos_q[$];
    logic [25:0] res_q[$];
    logic [25:0] last_final;
    logic [25:0] mon_e;
    logic        flying   = 1'b0;
    logic        saw_tick = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Trajectory straight from the flight rules, using ordinary integers.
    task automatic model_shot(input int spd, input int trn, input int lo, input int hi);
        int x, y, vy, xn, yn;
        bit fin, h;
        plan_q.delete();
        x   = trn ? SX_R : SX_L;
        y   = SY;
        vy  = -16;
        fin = 0;
        while (!fin) begin
            xn = trn ? x - spd : x + spd;
            yn = y + vy;
            vy = (vy + 1 > 31) ? 31 : vy + 1;
            if (xn < 0 || xn >= SW) begin
                x = (xn < 0) ? 0 : SW - 1;
                plan_q.push_back({12'(x), 12'(yn), 1'b0, 1'b1});
                fin = 1;
            end else if (yn >= GY) begin
                h = (lo <= xn) && (xn <= hi);
                plan_q.push_back({12'(xn), 12'(GY), h, !h});
                fin = 1;
            end else begin
                x = xn;
                y = yn;
                plan_q.push_back({12'(x), 12'(y), 1'b0, 1'b0});
            end
        end
    endtask

    always @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) saw_tick <= 1'b0;
        else        saw_tick <= frame_tick_i && flying;
    end

    always @(negedge clk60MHz) begin
        if (rst_n) begin
            if (saw_tick) begin
                if (pos_q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    mon_e = pos_q.pop_front();
                    chk("tick_x", ball_x_o, mon_e[25:14]);
                    chk("tick_y", ball_y_o, mon_e[13:2]);
                    chk("tick_hit", hit_o, mon_e[1]);
                    chk("tick_miss", miss_o, mon_e[0]);
                end
            end
            if (done_o) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = res_q.pop_front();
                    chk("done_x", ball_x_o, mon_e[25:14]);
                    chk("done_y", ball_y_o, mon_e[13:2]);
                    chk("done_hit", hit_o, mon_e[1]);
                    chk("done_miss", miss_o, mon_e[0]);
                    chk("done_busy", busy_o, 1);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic fire(input int spd, input int trn, input int lo, input int hi,
                        input bit tick_at_launch, input bit spam, input int abort_at);
        int n;
        logic [25:0] e;
        model_shot(spd, trn, lo, hi);
        n            = plan_q.size();
        speed_i      = 5'(spd);
        turn_i       = trn[0];
        target_lo_i  = 12'(lo);
        target_hi_i  = 12'(hi);
        launch_i     = 1'b1;
        frame_tick_i = tick_at_launch;
        @(negedge clk60MHz);
        launch_i     = 1'b0;
        frame_tick_i = 1'b0;
        chk("launch_busy", busy_o, 1);
        chk("launch_x", ball_x_o, trn ? SX_R : SX_L);
        chk("launch_y", ball_y_o, SY);
        chk("launch_hit", hit_o, 0);
        chk("launch_miss", miss_o, 0);
        flying = 1'b1;
        for (int k = 1; k <= n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk60MHz);
            if (abort_at == k) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy_o, 0);
                chk("rst_x", ball_x_o, SX_L);
                chk("rst_y", ball_y_o, SY);
                chk("rst_hit", hit_o, 0);
                chk("rst_miss", miss_o, 0);
                chk("rst_done", done_o, 0);
                flying = 1'b0;
                pos_q.delete();
                plan_q.delete();
                @(negedge clk60MHz);
                rst_n = 1'b1;
                @(negedge clk60MHz);
                return;
            end
            e = plan_q.pop_front();
            pos_q.push_back(e);
            if (k == n) begin
                res_q.push_back(e);
                last_final = e;
            end
            frame_tick_i = 1'b1;
            if (spam) begin
                launch_i = 1'b1;
                speed_i  = 5'($urandom_range(0, 31));
                turn_i   = 1'($urandom_range(0, 1));
            end
            @(negedge clk60MHz);
            frame_tick_i = 1'b0;
            launch_i     = 1'b0;
        end
        flying = 1'b0;
        @(negedge clk60MHz);
        chk("done_pulse", done_o, 1);
        chk("done_cycle_busy", busy_o, 1);
    endtask

    // After the done cycle: busy drops, done is a single pulse, stray ticks move nothing.
    task automatic idle_check();
        @(negedge clk60MHz);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        frame_tick_i = 1'b1;
        @(negedge clk60MHz);
        frame_tick_i = 1'b0;
        @(negedge clk60MHz);
        chk("idle_hold_x", ball_x_o, last_final[25:14]);
        chk("idle_hold_y", ball_y_o, last_final[13:2]);
        chk("idle_hold_hit", hit_o, last_final[1]);
        chk("idle_hold_miss", miss_o, last_final[0]);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int spd, trn, lo, hi, tmp;
        rst_n        = 1'b0;
        launch_i     = 1'b0;
        speed_i      = '0;
        turn_i       = 1'b0;
        frame_tick_i = 1'b0;
        target_lo_i  = '0;
        target_hi_i  = '0;
        repeat (3) @(negedge clk60MHz);
        chk("reset_x", ball_x_o, SX_L);
        chk("reset_y", ball_y_o, SY);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_hit", hit_o, 0);
        chk("reset_miss", miss_o, 0);
        rst_n = 1'b1;
        @(negedge clk60MHz);

        fire(10, 0, 500, 560, 1, 0, 0);
        chk("plan1_x", ball_x_o, 530);
        chk("plan1_y", ball_y_o, 700);
        chk("plan1_hit", hit_o, 1);
        idle_check();

        fire(10, 0, 600, 700, 0, 0, 0);
        chk("plan2_x", ball_x_o, 530);
        chk("plan2_miss", miss_o, 1);
        chk("plan2_hit", hit_o, 0);
        idle_check();

        fire(31, 0, 0, 1023, 0, 0, 0);
        chk("plan3_x", ball_x_o, 1023);
        chk("plan3_miss", miss_o, 1);
        chk("plan3_hit", hit_o, 0);
        idle_check();

        fire(20, 1, 40, 80, 1, 0, 0);
        chk("plan4_x", ball_x_o, 64);
        chk("plan4_y", ball_y_o, 700);
        chk("plan4_hit", hit_o, 1);
        // Re-arm on the earliest accepted edge.
        fire(7, 1, 0, 1023, 0, 0, 0);
        idle_check();

        fire(0, 0, 100, 100, 0, 1, 0);
        chk("plan5_x", ball_x_o, 100);
        chk("plan5_y", ball_y_o, 700);
        chk("plan5_hit", hit_o, 1);
        idle_check();

        fire(10, 0, 560, 500, 0, 0, 0);
        chk("empty_win_miss", miss_o, 1);
        idle_check();

        fire(10, 0, 500, 560, 0, 0, 20);
        fire(10, 0, 500, 560, 0, 0, 0);
        chk("post_rst_hit", hit_o, 1);
        idle_check();

        for (int s = 0; s < 16; s++) begin
            spd = $urandom_range(0, 31);
            trn = $urandom_range(0, 1);
            lo  = $urandom_range(0, 1023);
            hi  = lo + $urandom_range(0, 300);
            if (hi > 1023) hi = 1023;
            if ($urandom_range(0, 3) == 0) begin
                tmp = lo;
                lo  = hi;
                hi  = tmp;
            end
            fire(spd, trn, lo, hi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        repeat (4) @(negedge clk60MHz);
        chk("pos_queue_drained", pos_q.size(), 0);
        chk("res_queue_drained", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
